adder_datapath: RTL and testbench

//  Datapath for the adding machine; sits directly downstream of the controller FSM.

---
 rtl/adder_datapath.sv | 137 +++++++++++++
 tb/tb_adder_datapath.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/adder_datapath.sv
// Datapath of the adding machine: PC, IR, accumulator, memory address mux and ADD.
// Registers update one clock after their strobe; the address mux and strobes have zero latency.
// No backpressure. The controller strobes are applied every cycle. Optional flags use `ADDER_DP_FLAGS_EN.
module adder_datapath #(
    parameter int OPCODE_W = 3,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 8   // must equal OPCODE_W + ADDR_W
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                load_IR,
    input  logic                load_acc,
    input  logic                ld_pc,
    input  logic                clr_pc,
    input  logic                inc_pc,
    input  logic                sel_alu,
    input  logic                ir_on_adr,
    input  logic                pc_on_adr,
    input  logic                mem_read,
    input  logic                mem_write,
    output logic [OPCODE_W-1:0] opcode,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                mem_re,
    output logic                mem_we,
    output logic [DATA_W-1:0]   acc_out,
    output logic [ADDR_W-1:0]   pc_out,
    output logic                carry_flag,
    output logic                zero_flag
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] acc_q, acc_d;

    // PC next state: clear beats increment, increment beats jump.
    always_comb begin
        pc_d = pc_q;
        if (clr_pc) begin
            pc_d = '0;
        end else if (inc_pc) begin
            pc_d = pc_q + ADDR_W'(1);
        end else if (ld_pc) begin
            pc_d = ir_q[ADDR_W-1:0];
        end
    end

    // IR captures the memory word on an instruction fetch.
    always_comb begin
        ir_d = ir_q;
        if (load_IR) begin
            ir_d = mem_rdata;
        end
    end

`ifdef ADDER_DP_FLAGS_EN
    logic [DATA_W:0] sum_w;
    logic            carry_q, carry_d;
    logic            zero_q, zero_d;

    assign sum_w = {1'b0, acc_q} + {1'b0, mem_rdata};

    // Accumulator and flags: flags only move when the accumulator is written.
    always_comb begin
        acc_d   = acc_q;
        carry_d = carry_q;
        zero_d  = zero_q;
        if (load_acc) begin
            if (sel_alu) begin
                acc_d   = sum_w[DATA_W-1:0];
                carry_d = sum_w[DATA_W];
            end else begin
                acc_d   = mem_rdata;
                carry_d = 1'b0;
            end
            zero_d = (acc_d == '0);
        end
    end

    // Flag registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            carry_q <= carry_d;
            zero_q  <= zero_d;
        end
    end

    assign carry_flag = carry_q;
    assign zero_flag  = zero_q;
`else
    // Accumulator: plain load or add; sel_alu alone does nothing.
    always_comb begin
        acc_d = acc_q;
        if (load_acc) begin
            acc_d = sel_alu ? (acc_q + mem_rdata) : mem_rdata;
        end
    end

    assign carry_flag = 1'b0;
    assign zero_flag  = 1'b0;
`endif

    // Architectural registers; every update samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q  <= '0;
            ir_q  <= '0;
            acc_q <= '0;
        end else begin
            pc_q  <= pc_d;
            ir_q  <= ir_d;
            acc_q <= acc_d;
        end
    end

    // Address mux: PC has priority over the IR address field.
    always_comb begin
        mem_addr = '0;
        if (pc_on_adr) begin
            mem_addr = pc_q;
        end else if (ir_on_adr) begin
            mem_addr = ir_q[ADDR_W-1:0];
        end
    end

    assign opcode    = ir_q[DATA_W-1 -: OPCODE_W];
    assign mem_wdata = acc_q;
    assign mem_re    = mem_read;
    assign mem_we    = mem_write;
    assign acc_out   = acc_q;
    assign pc_out    = pc_q;

endmodule

// File: tb/tb_adder_datapath.sv
// Bench for adder_datapath: directed corner cases plus randomized strobes
// against an arithmetic model of the PC / IR / accumulator.
module tb_adder_datapath;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       load_IR, load_acc, ld_pc, clr_pc, inc_pc, sel_alu;
    logic       ir_on_adr, pc_on_adr, mem_read, mem_write;
    logic [2:0] opcode;
    logic [4:0] mem_addr;
    logic [7:0] mem_wdata, mem_rdata, acc_out;
    logic       mem_re, mem_we;
    logic [4:0] pc_out;
    logic       carry_flag, zero_flag;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Reference state as plain integers.
    int m_pc = 0, m_ir = 0, m_acc = 0, m_c = 0, m_z = 0;

    adder_datapath #(.OPCODE_W(3), .ADDR_W(5), .DATA_W(8)) dut (
        .clock(clock), .reset(reset),
        .load_IR(load_IR), .load_acc(load_acc), .ld_pc(ld_pc), .clr_pc(clr_pc),
        .inc_pc(inc_pc), .sel_alu(sel_alu), .ir_on_adr(ir_on_adr), .pc_on_adr(pc_on_adr),
        .mem_read(mem_read), .mem_write(mem_write), .opcode(opcode), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_re(mem_re), .mem_we(mem_we),
        .acc_out(acc_out), .pc_out(pc_out), .carry_flag(carry_flag), .zero_flag(zero_flag)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: what each register must hold after an edge, from the rules.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_pc = 0; m_ir = 0; m_acc = 0; m_c = 0; m_z = 0;
        end else begin
            int s;
            int npc;
            npc = m_pc;
            if (clr_pc)      npc = 0;
            else if (inc_pc) npc = (m_pc + 1) % 32;
            else if (ld_pc)  npc = m_ir % 32;
            if (load_acc) begin
`ifdef ADDER_DP_FLAGS_EN
                if (sel_alu) begin
                    s   = m_acc + int'(mem_rdata);
                    m_c = (s > 255) ? 1 : 0;
                end else begin
                    s   = int'(mem_rdata);
                    m_c = 0;
                end
                m_acc = s % 256;
                m_z   = (m_acc == 0) ? 1 : 0;
`else
                s     = sel_alu ? m_acc + int'(mem_rdata) : int'(mem_rdata);
                m_acc = s % 256;
`endif
            end
            if (load_IR) m_ir = int'(mem_rdata);
            m_pc = npc;
        end
    end

    // Compare process: every output vs the model, mid-cycle.
    always @(negedge clock) begin
        if (chk_en) begin
            int exp_addr;
            exp_addr = pc_on_adr ? m_pc : (ir_on_adr ? (m_ir % 32) : 0);
            chk("pc_out",    int'(pc_out),     m_pc);
            chk("acc_out",   int'(acc_out),    m_acc);
            chk("opcode",    int'(opcode),     m_ir / 32);
            chk("mem_addr",  int'(mem_addr),   exp_addr);
            chk("mem_wdata", int'(mem_wdata),  m_acc);
            chk("mem_re",    int'(mem_re),     int'(mem_read));
            chk("mem_we",    int'(mem_we),     int'(mem_write));
            chk("carry",     int'(carry_flag), m_c);
            chk("zero",      int'(zero_flag),  m_z);
        end
    end

    task automatic idle();
        load_IR = 0; load_acc = 0; ld_pc = 0; clr_pc = 0; inc_pc = 0; sel_alu = 0;
        ir_on_adr = 0; pc_on_adr = 0; mem_read = 0; mem_write = 0; mem_rdata = 8'h00;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        idle();
    endtask

    initial begin
        idle();
        chk_en = 1'b1;
        #12;
        chk("rst_acc", int'(acc_out), 0);
        chk("rst_pc",  int'(pc_out),  0);
        chk("rst_op",  int'(opcode),  0);
        chk("rst_we",  int'(mem_we),  0);
        @(posedge clock); #1;
        reset = 1'b0;

        // PC wrap: load 31 via IR, jump, then increment.
        mem_rdata = 8'h1F; load_IR = 1; step();
        ld_pc = 1; step();
        chk("pc_31", int'(pc_out), 31);
        inc_pc = 1; step();
        chk("pc_wrap", int'(pc_out), 0);
        inc_pc = 1; step();
        clr_pc = 1; inc_pc = 1; step();
        chk("pc_clr_inc", int'(pc_out), 0);

        // Fetch 0x45: opcode 2, address field 5, jump to it.
        mem_rdata = 8'h45; load_IR = 1; step();
        chk("op_45", int'(opcode), 2);
        ir_on_adr = 1; #1;
        chk("addr_ir", int'(mem_addr), 5);
        ld_pc = 1; step();
        chk("pc_jump", int'(pc_out), 5);

        // Add with carry-out: F0 + 20 = 10.
        mem_rdata = 8'hF0; load_acc = 1; step();
        mem_rdata = 8'h20; load_acc = 1; sel_alu = 1; step();
        chk("acc_add", int'(acc_out), 8'h10);
`ifdef ADDER_DP_FLAGS_EN
        chk("carry_add", int'(carry_flag), 1);
        chk("zero_add",  int'(zero_flag),  0);
`else
        chk("carry_off", int'(carry_flag), 0);
`endif
        // Plain load of zero.
        mem_rdata = 8'h00; load_acc = 1; step();
        chk("acc_zero", int'(acc_out), 0);
`ifdef ADDER_DP_FLAGS_EN
        chk("zero_ld",  int'(zero_flag),  1);
        chk("carry_ld", int'(carry_flag), 0);
`else
        chk("zero_off", int'(zero_flag), 0);
`endif
        // Read-before-write on mem_wdata.
        mem_rdata = 8'h33; load_acc = 1; step();
        mem_write = 1; load_acc = 1; mem_rdata = 8'h01; #1;
        chk("we_same", int'(mem_we), 1);
        chk("wdata_old", int'(mem_wdata), 8'h33);
        step();
        chk("acc_new", int'(acc_out), 8'h01);

        // Async reset mid-cycle with acc=5A, pc=7.
        mem_rdata = 8'h07; load_IR = 1; step();
        ld_pc = 1; mem_rdata = 8'h5A; load_acc = 1; step();
        chk("pre_acc", int'(acc_out), 8'h5A);
        chk("pre_pc",  int'(pc_out),  7);
        #2; reset = 1'b1; #1;
        chk("ar_acc", int'(acc_out), 0);
        chk("ar_pc",  int'(pc_out),  0);
        chk("ar_op",  int'(opcode),  0);
        chk("ar_ir",  int'(dut.ir_q), 0);
        step();
        reset = 1'b0;

        // Randomized strobes, with rare reset pulses.
        for (int i = 0; i < 3000; i++) begin
            step();
            reset     = ($urandom_range(0, 199) == 0);
            load_IR   = $urandom_range(0, 3) == 0;
            load_acc  = $urandom_range(0, 2) == 0;
            ld_pc     = $urandom_range(0, 3) == 0;
            clr_pc    = $urandom_range(0, 15) == 0;
            inc_pc    = $urandom_range(0, 2) == 0;
            sel_alu   = $urandom_range(0, 1) == 1;
            ir_on_adr = $urandom_range(0, 1) == 1;
            pc_on_adr = $urandom_range(0, 1) == 1;
            mem_read  = $urandom_range(0, 1) == 1;
            mem_write = $urandom_range(0, 1) == 1;
            mem_rdata = 8'($urandom_range(0, 255));
        end
        step();
        reset = 1'b0;
        step();
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
